// File: rtl/shift_arbiter2_if.sv
// shift_arbiter2_if: request, handshake and result bundle for the shared shifter
interface shift_arbiter2_if #(parameter int WIDTH = 8, parameter int SHW = 3);
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic [SHW-1:0]   a_shamt;
  logic [1:0]       a_op;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [SHW-1:0]   b_shamt;
  logic [1:0]       b_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_id;
  modport master (
    output a_valid, a_data, a_shamt, a_op, b_valid, b_data, b_shamt, b_op, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_id
  );
  modport slave (
    input  a_valid, a_data, a_shamt, a_op, b_valid, b_data, b_shamt, b_op, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/shift_arbiter2.sv
// shift_arbiter2: round-robin sharing of one barrel shifter between two requesters
module shift_arbiter2 #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input logic             clk,
  input logic             rst,
  shift_arbiter2_if.slave bus
);
  logic             r_valid;
  logic             r_id;
  logic             r_last;
  logic [WIDTH-1:0] r_data;
  logic             w_can;
  logic             w_gnt_b;
  logic             w_acc;
  logic             w_fill;
  logic [WIDTH-1:0] w_data;
  logic [SHW-1:0]   w_shamt;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_stg [SHW+1];
  assign w_can       = !r_valid | bus.out_ready;
  // r_last=1 means B won last, so A takes a tie
  assign w_gnt_b     = bus.b_valid & (!bus.a_valid | !r_last);
  assign bus.a_ready = !rst & w_can & bus.a_valid & !w_gnt_b;
  assign bus.b_ready = !rst & w_can & w_gnt_b;
  assign w_acc       = bus.a_ready | bus.b_ready;
  assign w_data      = w_gnt_b ? bus.b_data  : bus.a_data;
  assign w_shamt     = w_gnt_b ? bus.b_shamt : bus.a_shamt;
  assign w_op        = w_gnt_b ? bus.b_op    : bus.a_op;
  assign w_fill      = (w_op == 2'b10) & w_data[WIDTH-1];
  assign w_stg[0]    = w_data;
  for (genvar k = 0; k < SHW; k++) begin : g_stg
    localparam int D = 1 << k;
    assign w_stg[k+1] = !w_shamt[k]      ? w_stg[k] :
                        w_op == 2'b00    ? {w_stg[k][WIDTH-1-D:0], {D{1'b0}}} :
                        w_op == 2'b11    ? {w_stg[k][WIDTH-1-D:0], w_stg[k][WIDTH-1:WIDTH-D]} :
                                           {{D{w_fill}}, w_stg[k][WIDTH-1:D]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else if (w_acc) begin
      r_valid <= 1'b1;
      r_data  <= w_stg[SHW];
      r_id    <= w_gnt_b;
      r_last  <= w_gnt_b;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_id    = r_id;
endmodule

// File: tb/tb_shift_arbiter2.sv
// tb_shift_arbiter2: directed and randomized checks against a rule-level model
module tb_shift_arbiter2;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_id;
  logic       m_last;
  shift_arbiter2_if #(.WIDTH(8), .SHW(3)) bus ();
  shift_arbiter2 #(.WIDTH(8), .SHW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s, input logic [1:0] op);
    logic [15:0] t;
    t = {d, d} << s;
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return 8'($signed(d) >>> s);
      default: return t[15:8];
    endcase
  endfunction
  // {b_ready, a_ready} expected from the arbitration rules
  function automatic logic [1:0] exp_rdy();
    if (rst || (m_valid && !bus.out_ready)) return 2'b00;
    if (bus.a_valid && bus.b_valid) return m_last ? 2'b01 : 2'b10;
    if (bus.a_valid) return 2'b01;
    if (bus.b_valid) return 2'b10;
    return 2'b00;
  endfunction
  task automatic tick();
    logic [1:0] r;
    r = exp_rdy();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_data = 0; m_id = 0; m_last = 1;
    end else if (r[0]) begin
      m_valid = 1; m_data = ref_shift(bus.a_data, bus.a_shamt, bus.a_op); m_id = 0; m_last = 0;
    end else if (r[1]) begin
      m_valid = 1; m_data = ref_shift(bus.b_data, bus.b_shamt, bus.b_op); m_id = 1; m_last = 1;
    end else if (bus.out_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask
  task automatic set_a(input logic v, input logic [7:0] d, input logic [2:0] s, input logic [1:0] op);
    bus.a_valid = v; bus.a_data = d; bus.a_shamt = s; bus.a_op = op;
  endtask
  task automatic set_b(input logic v, input logic [7:0] d, input logic [2:0] s, input logic [1:0] op);
    bus.b_valid = v; bus.b_data = d; bus.b_shamt = s; bus.b_op = op;
  endtask
  task automatic test_reset();
    rst = 1;
    set_a(1, 8'h11, 1, 0);
    set_b(1, 8'h22, 1, 0);
    bus.out_ready = 1;
    tick();
    #1;
    n_cmp++;
    if ({bus.b_ready, bus.a_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready got=%b want=00", {bus.b_ready, bus.a_ready});
    end
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_id} !== 10'd0) begin
      n_err++; $display("FAIL reset_out got v=%b d=%h id=%b want 0/00/0", bus.out_valid, bus.out_data, bus.out_id);
    end
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    rst = 0;
    tick();
  endtask
  task automatic test_ops();
    logic [7:0] d [5]   = '{8'hB4, 8'h96, 8'h96, 8'h96, 8'h96};
    logic [2:0] s [5]   = '{3'd3, 3'd2, 3'd2, 3'd2, 3'd0};
    logic [1:0] op [5]  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    logic [7:0] exp [5] = '{8'hA0, 8'h25, 8'hE5, 8'h5A, 8'h96};
    bus.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      set_a(1, d[i], s[i], op[i]);
      #1;
      n_cmp++;
      if (bus.a_ready !== 1'b1) begin
        n_err++; $display("FAIL ops_ready[%0d] got=%b want=1", i, bus.a_ready);
      end
      tick();
      set_a(0, 0, 0, 0);
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp[i] || bus.out_id !== 1'b0) begin
        n_err++;
        $display("FAIL ops[%0d] got v=%b d=%h id=%b want 1/%h/0", i, bus.out_valid, bus.out_data, bus.out_id, exp[i]);
      end
      tick();
    end
  endtask
  task automatic test_alternate();
    rst = 1; tick(); rst = 0;
    bus.out_ready = 1;
    set_a(1, 8'($urandom), 3'($urandom), 2'($urandom));
    set_b(1, 8'($urandom), 3'($urandom), 2'($urandom));
    for (int i = 0; i < 6; i++) begin
      #1;
      n_cmp++;
      if ({bus.b_ready, bus.a_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_err++; $display("FAIL alt_grant[%0d] got=%b want=%b", i, {bus.b_ready, bus.a_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_id !== 1'(i % 2) || bus.out_data !== m_data) begin
        n_err++;
        $display("FAIL alt_out[%0d] got v=%b id=%b d=%h want 1/%0d/%h", i, bus.out_valid, bus.out_id, bus.out_data, i % 2, m_data);
      end
      if (i % 2 == 0) set_a(1, 8'($urandom), 3'($urandom), 2'($urandom));
      else set_b(1, 8'($urandom), 3'($urandom), 2'($urandom));
    end
  endtask
  task automatic test_stall();
    logic [7:0] sd;
    logic       sid;
    bus.out_ready = 1;
    tick();
    sd = bus.out_data;
    sid = bus.out_id;
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({bus.b_ready, bus.a_ready} !== 2'b00) begin
        n_err++; $display("FAIL stall_ready[%0d] got=%b want=00", i, {bus.b_ready, bus.a_ready});
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== sd || bus.out_id !== sid) begin
        n_err++; $display("FAIL stall_hold[%0d] got v=%b d=%h id=%b want 1/%h/%b", i, bus.out_valid, bus.out_data, bus.out_id, sd, sid);
      end
    end
    bus.out_ready = 1;
    #1;
    n_cmp++;
    if ({bus.b_ready, bus.a_ready} !== (sid ? 2'b01 : 2'b10)) begin
      n_err++; $display("FAIL stall_release got=%b want=%b", {bus.b_ready, bus.a_ready}, sid ? 2'b01 : 2'b10);
    end
    tick();
  endtask
  task automatic test_back_to_back();
    logic [7:0] hd;
    bus.out_ready = 1;
    set_a(1, 8'h0F, 3'd4, 2'b00);
    set_b(0, 0, 0, 0);
    tick();
    set_a(0, 0, 0, 0);
    set_b(1, 8'h81, 3'd1, 2'b10);
    #1;
    n_cmp++;
    if (bus.b_ready !== 1'b1 || bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready got b_ready=%b v=%b want 1/1", bus.b_ready, bus.out_valid);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC0 || bus.out_id !== 1'b1) begin
      n_err++; $display("FAIL b2b_data got v=%b d=%h id=%b want 1/c0/1", bus.out_valid, bus.out_data, bus.out_id);
    end
    set_b(0, 0, 0, 0);
    hd = bus.out_data;
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== hd || bus.out_id !== 1'b1) begin
      n_err++; $display("FAIL drain got v=%b d=%h id=%b want 0/%h/1", bus.out_valid, bus.out_data, bus.out_id, hd);
    end
  endtask
  task automatic test_reset_mid();
    bus.out_ready = 0;
    set_a(1, 8'h33, 3'd1, 2'b11);
    tick();
    set_a(0, 0, 0, 0);
    set_b(1, 8'h44, 3'd2, 2'b01);
    rst = 1;
    bus.out_ready = 1;
    #1;
    n_cmp++;
    if ({bus.b_ready, bus.a_ready} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_ready got=%b want=00", {bus.b_ready, bus.a_ready});
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmid_valid got=%b want=0", bus.out_valid);
    end
    rst = 0;
    set_a(1, 8'h55, 3'd0, 2'b00);
    #1;
    n_cmp++;
    if ({bus.b_ready, bus.a_ready} !== 2'b01) begin
      n_err++; $display("FAIL rstmid_prio got=%b want=01", {bus.b_ready, bus.a_ready});
    end
    tick();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    tick();
  endtask
  task automatic test_random();
    logic [1:0] r;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if (!bus.a_valid) set_a(1'($urandom_range(0, 9) < 6), 8'($urandom), 3'($urandom), 2'($urandom));
      if (!bus.b_valid) set_b(1'($urandom_range(0, 9) < 6), 8'($urandom), 3'($urandom), 2'($urandom));
      bus.out_ready = 1'($urandom_range(0, 3) != 0);
      #1;
      r = exp_rdy();
      n_cmp++;
      if ({bus.b_ready, bus.a_ready} !== r) begin
        n_err++; $display("FAIL rnd_ready[%0d] got=%b want=%b", i, {bus.b_ready, bus.a_ready}, r);
      end
      tick();
      n_cmp++;
      if (bus.out_valid !== m_valid || (m_valid && (bus.out_data !== m_data || bus.out_id !== m_id))) begin
        n_err++;
        $display("FAIL rnd_out[%0d] got v=%b d=%h id=%b want %b/%h/%b", i, bus.out_valid, bus.out_data, bus.out_id, m_valid, m_data, m_id);
      end
      if (r[0]) bus.a_valid = 0;
      if (r[1]) bus.b_valid = 0;
    end
  endtask
  initial begin
    clk = 0;
    rst = 1;
    n_cmp = 0;
    n_err = 0;
    m_valid = 0; m_data = 0; m_id = 0; m_last = 1;
    bus.out_ready = 0;
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_ops();
    test_alternate();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
